// File: rtl/relu_pool.sv
// ReLU + 2x2 max-pool + requantise stage between a conv output SRAM and the
// next layer's pixel SRAM. One window every 6 cycles: 4 reads, 1 drain, 1 write.
module relu_pool #(
    parameter int DATA_WIDTH = 20,
    parameter int ADDR_WIDTH = 10,
    parameter int OUT_WIDTH  = 9,
    parameter int FMAP_W     = 30,
    parameter int FMAP_H     = 30,
    parameter int SHIFT      = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  finish,
    output logic                  conv_out_req,
    output logic [ADDR_WIDTH-1:0] conv_out_addr,
    input  logic [DATA_WIDTH-1:0] conv_out_data,
    output logic                  pool_req,
    output logic [ADDR_WIDTH-1:0] pool_addr,
    output logic [OUT_WIDTH-1:0]  pool_data
);

    localparam int WIN_W = FMAP_W / 2;
    localparam int WIN_H = FMAP_H / 2;
    localparam int SAT   = (1 << (OUT_WIDTH - 1)) - 1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        LAST = 3'd2,
        WR   = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t                         state_r, state_nxt_s;
    logic [1:0]                     rd_cnt_r, rd_cnt_nxt_s;
    logic [ADDR_WIDTH-1:0]          wc_r, wc_nxt_s;
    logic [ADDR_WIDTH-1:0]          wr_r, wr_nxt_s;
    logic [ADDR_WIDTH-1:0]          win_r, win_nxt_s;
    logic [ADDR_WIDTH-1:0]          addr_nxt_s;
    logic signed [DATA_WIDTH-1:0]   max_r;
    logic signed [DATA_WIDTH-1:0]   word_s;
    logic signed [DATA_WIDTH-1:0]   cand_s;
    logic                           last_win_s;

    // Negative clamps to zero, then logical shift and saturate to the positive range.
    function automatic logic [OUT_WIDTH-1:0] requant(input logic signed [DATA_WIDTH-1:0] m);
        logic [DATA_WIDTH-1:0] r;
        logic [DATA_WIDTH-1:0] q;
        r = m[DATA_WIDTH-1] ? {DATA_WIDTH{1'b0}} : m;
        q = r >> SHIFT;
        if (q > DATA_WIDTH'(SAT)) begin
            requant = OUT_WIDTH'(SAT);
        end else begin
            requant = q[OUT_WIDTH-1:0];
        end
    endfunction

    assign word_s     = $signed(conv_out_data);
    assign cand_s     = (word_s > max_r) ? word_s : max_r;
    assign last_win_s = (wc_r == ADDR_WIDTH'(WIN_W - 1)) && (wr_r == ADDR_WIDTH'(WIN_H - 1));

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state plus next read/window counters
    always_comb begin
        state_nxt_s  = state_r;
        rd_cnt_nxt_s = (state_r == RD) ? rd_cnt_r + 2'd1 : 2'd0;
        wc_nxt_s     = wc_r;
        wr_nxt_s     = wr_r;
        win_nxt_s    = win_r;
        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt_s = RD;
                    wc_nxt_s    = {ADDR_WIDTH{1'b0}};
                    wr_nxt_s    = {ADDR_WIDTH{1'b0}};
                    win_nxt_s   = {ADDR_WIDTH{1'b0}};
                end else begin
                    state_nxt_s = state_r;
                end
            end
            RD: begin
                if (rd_cnt_r == 2'd3) begin
                    state_nxt_s = LAST;
                end else begin
                    state_nxt_s = RD;
                end
            end
            LAST: state_nxt_s = WR;
            WR: begin
                state_nxt_s = last_win_s ? DONE : RD;
                win_nxt_s   = win_r + ADDR_WIDTH'(1);
                if (wc_r == ADDR_WIDTH'(WIN_W - 1)) begin
                    wc_nxt_s = {ADDR_WIDTH{1'b0}};
                    wr_nxt_s = wr_r + ADDR_WIDTH'(1);
                end else begin
                    wc_nxt_s = wc_r + ADDR_WIDTH'(1);
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Read address for the upcoming cycle: window base plus 2x2 offset
    always_comb begin
        addr_nxt_s = (wr_nxt_s * ADDR_WIDTH'(2 * FMAP_W)) + wc_nxt_s + wc_nxt_s;
        case (rd_cnt_nxt_s)
            2'd0:    addr_nxt_s = addr_nxt_s;
            2'd1:    addr_nxt_s = addr_nxt_s + ADDR_WIDTH'(1);
            2'd2:    addr_nxt_s = addr_nxt_s + ADDR_WIDTH'(FMAP_W);
            2'd3:    addr_nxt_s = addr_nxt_s + ADDR_WIDTH'(FMAP_W + 1);
            default: addr_nxt_s = {ADDR_WIDTH{1'b0}};
        endcase
    end

    // Counters and running max; read data lags its request by one cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_cnt_r <= 2'd0;
            wc_r     <= {ADDR_WIDTH{1'b0}};
            wr_r     <= {ADDR_WIDTH{1'b0}};
            win_r    <= {ADDR_WIDTH{1'b0}};
            max_r    <= {DATA_WIDTH{1'b0}};
        end else begin
            rd_cnt_r <= rd_cnt_nxt_s;
            wc_r     <= wc_nxt_s;
            wr_r     <= wr_nxt_s;
            win_r    <= win_nxt_s;
            if (state_r == RD && rd_cnt_r == 2'd1) begin
                max_r <= word_s;
            end else if ((state_r == RD && rd_cnt_r[1]) || state_r == LAST) begin
                max_r <= cand_s;
            end else begin
                max_r <= max_r;
            end
        end
    end

    // Registered outputs, derived from the next state so they align with it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            finish        <= 1'b0;
            conv_out_req  <= 1'b0;
            conv_out_addr <= {ADDR_WIDTH{1'b0}};
            pool_req      <= 1'b0;
            pool_addr     <= {ADDR_WIDTH{1'b0}};
            pool_data     <= {OUT_WIDTH{1'b0}};
        end else begin
            finish        <= (state_nxt_s == DONE);
            conv_out_req  <= (state_nxt_s == RD);
            conv_out_addr <= (state_nxt_s == RD) ? addr_nxt_s : {ADDR_WIDTH{1'b0}};
            pool_req      <= (state_nxt_s == WR);
            if (state_nxt_s == WR) begin
                pool_addr <= win_r;
                pool_data <= requant(cand_s);
            end else begin
                pool_addr <= pool_addr;
                pool_data <= pool_data;
            end
        end
    end

endmodule

// File: doc/relu_pool.md
RELU_POOL -- requirements
Module: relu_pool

Interface
REQ-001 Parameter DATA_WIDTH, 20: conv result word width, signed two's complement.
REQ-002 Parameter ADDR_WIDTH, 10: address width of both SRAM ports.
REQ-003 Parameter OUT_WIDTH, 9: pooled output width; matches the next conv layer's pixel width.
REQ-004 Parameter FMAP_W, 30: conv feature-map width in words, minimum 2.
REQ-005 Parameter FMAP_H, 30: conv feature-map height in rows, minimum 2.
REQ-006 Parameter SHIFT, 6: requantization right-shift amount.
REQ-007 clk  in  1  single clock; all state changes on its rising edge.
REQ-008 reset  in  1  asynchronous, active-low reset.
REQ-009 start  in  1  run request, sampled only in IDLE or DONE.
REQ-010 finish  out  1  run complete, level.
REQ-011 conv_out_req  out  1  read request to the conv output SRAM.
REQ-012 conv_out_addr  out  ADDR_WIDTH  read address, row-major (row*FMAP_W+col).
REQ-013 conv_out_data  in  DATA_WIDTH  read data, valid exactly 1 cycle after its request.
REQ-014 pool_req  out  1  write strobe to the pooled SRAM, 1 cycle per word.
REQ-015 pool_addr  out  ADDR_WIDTH  write address.
REQ-016 pool_data  out  OUT_WIDTH  write data, unsigned value in the range 0..2^(OUT_WIDTH-1)-1.

Function
REQ-017 The FSM SHALL have the states IDLE, RD, LAST, WR and DONE.
REQ-018 IDLE/DONE with start=1 at an edge SHALL go to RD with window index 0; DONE with start=1 SHALL drop finish on that edge.
REQ-019 start SHALL be ignored in RD, LAST and WR.
REQ-020 RD SHALL last exactly 4 cycles, asserting conv_out_req with addresses base, base+1, base+FMAP_W, base+FMAP_W+1 in that order; base=(2*wr)*FMAP_W+2*wc.
REQ-021 LAST SHALL last 1 cycle with conv_out_req=0, capturing the 4th read word.
REQ-022 WR SHALL last 1 cycle with pool_req=1, pool_addr=window index and pool_data=result; it then goes to RD for the next window, or to DONE after the last window.
REQ-023 Window period SHALL be 6 cycles, with no overlap between windows.
REQ-024 Windows SHALL be visited row-major: wc 0..FMAP_W/2-1 inner, wr 0..FMAP_H/2-1 outer; window count N=(FMAP_H/2)*(FMAP_W/2), with floor division.
REQ-025 For odd FMAP_W/FMAP_H, the trailing column/row SHALL never be read.
REQ-026 The window max SHALL be a signed compare over the 4 words, and the first word SHALL initialise the max (not 0).
REQ-027 Result SHALL be: r = max<0 ? 0 : max; q = r >> SHIFT (logical); pool_data = q > 2^(OUT_WIDTH-1)-1 ? 2^(OUT_WIDTH-1)-1 : q.
REQ-028 pool_addr SHALL run 0..N-1 consecutively; pool_req SHALL be 0 outside WR.
REQ-029 conv_out_req and pool_req SHALL never be high in the same cycle.
REQ-030 In DONE, finish SHALL be 1 and both req outputs SHALL be 0.
REQ-031 With start at edge 0, RD SHALL occupy cycles 1-4, the first write SHALL occur at cycle 6, the last write at cycle 6N, and finish=1 from cycle 6N+1.

Reset
REQ-032 reset=0 SHALL force, asynchronously: state=IDLE, finish=0, conv_out_req=0, pool_req=0, conv_out_addr=0, pool_addr=0, pool_data=0, window counters=0, max register=0.
REQ-033 Reset asserted mid-run SHALL abort the run with no further requests; the next run SHALL restart from window 0.
REQ-034 After reset release, the block SHALL wait in IDLE for start.

Verification
REQ-035 Default params, start pulse at edge 0 -> reads 0,1,30,31 in cycles 1-4; write addr 0 at cycle 6; reads 2,3,32,33 in cycles 7-10; 225 writes (addrs 0..224); finish at cycle 1351.
REQ-036 Window words {100,-5,3000,64}, SHIFT=6 -> pool_data=46; all-negative map -> all 225 pool_data=0.
REQ-037 Window {-7,20'h7FFFF,0,1} -> pool_data=255 (saturated); window {-1,-2,-3,-4} -> 0.
REQ-038 FMAP_W=5, FMAP_H=3 -> 2 windows reading (0,1,5,6) then (2,3,7,8); addresses 4, 9, 10-14 never read; finish at cycle 13.
REQ-039 Reset low during window 3 RD -> all reqs 0 immediately; after release plus start -> the run restarts at addr 0, with 225 writes.
REQ-040 start held high through a run -> no restart while busy; in DONE, finish=1 for 1 cycle and then a new run begins.
